error_event_capture: RTL and testbench

- Upstream stage of the lifetime error counters.
- Decodes FDC end-of-command status bytes, drive fault lines and PLL lock into single-cycle error strobes plus an operation_complete strobe, one per event, in the form the counter block consumes.
- Also records every error event, with timestamp and track, in a small circular log the host drains over a pop handshake.

---
 rtl/flux_diag_pkg.sv | 35 +++
 rtl/event_log_fifo.sv | 75 +++++++
 rtl/error_event_capture.sv | 131 +++++++++++++
 tb/tb_error_event_capture.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/flux_diag_pkg.sv
// Shared definitions for the flux diagnostics blocks.
// Holds the uPD765 status-byte bit positions, the error-mask bit layout used
// by both the strobe outputs and the event log, and the log entry field widths.
package flux_diag_pkg;

    // ST1 bit positions
    localparam int unsigned ST1_MA = 0;   // missing address mark
    localparam int unsigned ST1_OR = 4;   // overrun / underrun
    localparam int unsigned ST1_DE = 5;   // data error (CRC)

    // ST2 bit positions
    localparam int unsigned ST2_MD = 0;   // missing data address mark
    localparam int unsigned ST2_DD = 5;   // CRC error in data field

    // Error mask bit positions, LSB first
    localparam int unsigned ERRMASK_CRC_DATA    = 0;
    localparam int unsigned ERRMASK_CRC_ADDR    = 1;
    localparam int unsigned ERRMASK_MISSING_AM  = 2;
    localparam int unsigned ERRMASK_MISSING_DAM = 3;
    localparam int unsigned ERRMASK_OVERRUN     = 4;
    localparam int unsigned ERRMASK_UNDERRUN    = 5;
    localparam int unsigned ERRMASK_SEEK        = 6;
    localparam int unsigned ERRMASK_WRITE_FAULT = 7;
    localparam int unsigned ERRMASK_PLL_UNLOCK  = 8;
    localparam int unsigned ERRMASK_W           = 9;

    // Log entry layout: {timestamp, track, mask}
    localparam int unsigned LOG_TRACK_W = 8;
    localparam int unsigned LOG_MASK_W  = ERRMASK_W;

    function automatic int unsigned log_entry_w(input int unsigned ts_w);
        return ts_w + LOG_TRACK_W + LOG_MASK_W;
    endfunction

endpackage

// File: rtl/event_log_fifo.sv
// Circular event log with overwrite-oldest on overflow.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   clear         : empties the log and clears overflow; beats push and pop
//   push, push_data : write one entry (always accepted)
//   pop           : consume head entry; ignored when empty
//   valid         : log non-empty
//   head          : oldest entry (meaningful when valid)
//   overflow      : sticky, set when an entry was discarded by a push
//   count         : entries held, 0..DEPTH
module event_log_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 41
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic                       valid,
    output logic [W-1:0]               head,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_next;
    logic          do_pop;
    logic          drop_oldest;

    always_comb begin
        do_pop      = pop && (count != '0);
        // Full log, push without a pop: the head is sacrificed to make room.
        drop_oldest = push && !do_pop && (count == FULL);
        count_next  = count;
        if (push && !do_pop && (count != FULL))
            count_next = count + CW'(1);
        else if (!push && do_pop)
            count_next = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop || drop_oldest)
                rd_ptr <= rd_ptr + AW'(1);
            if (drop_oldest)
                overflow <= 1'b1;
            count <= count_next;
            valid <= (count_next != '0);
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push && !clear && !reset)
            mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/error_event_capture.sv
// Error event capture: decodes FDC end-of-command status, seek result,
// drive write fault and PLL lock loss into one-cycle error strobes plus an
// operation_complete strobe, and logs each error event with a microsecond
// timestamp and the current track in a circular log drained by the host.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   cmd_done, cmd_is_write     : end-of-command pulse and its direction
//   st1, st2                   : uPD765 status bytes, valid with cmd_done
//   seek_done, seek_fail       : end-of-seek pulse and its result
//   drv_write_fault            : drive write fault level
//   pll_locked, op_active      : data separator lock, read/write in progress
//   cur_track                  : current cylinder, logged with each event
//   err_*                      : one-cycle error strobes
//   operation_complete         : one-cycle strobe per cmd_done
//   log_valid/log_data/log_pop : log head and consume handshake
//   log_clear                  : empty log, clear overflow
//   log_overflow, log_count    : sticky overwrite flag, entries held
module error_event_capture
    import flux_diag_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned TS_W       = 24,
    parameter int unsigned CLK_PER_US = 50
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_done,
    input  logic                   cmd_is_write,
    input  logic [7:0]             st1,
    input  logic [7:0]             st2,
    input  logic                   seek_done,
    input  logic                   seek_fail,
    input  logic                   drv_write_fault,
    input  logic                   pll_locked,
    input  logic                   op_active,
    input  logic [7:0]             cur_track,
    output logic                   err_crc_data,
    output logic                   err_crc_addr,
    output logic                   err_missing_am,
    output logic                   err_missing_dam,
    output logic                   err_overrun,
    output logic                   err_underrun,
    output logic                   err_seek,
    output logic                   err_write_fault,
    output logic                   err_pll_unlock,
    output logic                   operation_complete,
    output logic                   log_valid,
    output logic [TS_W+16:0]       log_data,
    input  logic                   log_pop,
    input  logic                   log_clear,
    output logic                   log_overflow,
    output logic [$clog2(DEPTH):0] log_count
);
    localparam int unsigned PRE_W   = $clog2(CLK_PER_US);
    localparam int unsigned ENTRY_W = log_entry_w(TS_W);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_US - 1);

    logic [ERRMASK_W-1:0] mask_next;
    logic [ERRMASK_W-1:0] mask_q;
    logic                 oc_q;
    logic                 wf_prev;
    logic                 pll_prev;
    logic [PRE_W-1:0]     prescale;
    logic [TS_W-1:0]      timestamp;

    always_comb begin
        mask_next = '0;
        if (cmd_done) begin
            mask_next[ERRMASK_CRC_DATA]    = st1[ST1_DE] &  st2[ST2_DD];
            mask_next[ERRMASK_CRC_ADDR]    = st1[ST1_DE] & ~st2[ST2_DD];
            mask_next[ERRMASK_MISSING_AM]  = st1[ST1_MA] & ~st2[ST2_MD];
            mask_next[ERRMASK_MISSING_DAM] = st2[ST2_MD];
            mask_next[ERRMASK_OVERRUN]     = st1[ST1_OR] & ~cmd_is_write;
            mask_next[ERRMASK_UNDERRUN]    = st1[ST1_OR] &  cmd_is_write;
        end
        mask_next[ERRMASK_SEEK]        = seek_done & seek_fail;
        mask_next[ERRMASK_WRITE_FAULT] = drv_write_fault & ~wf_prev;
        // Lock loss only matters while data is actually being transferred.
        mask_next[ERRMASK_PLL_UNLOCK]  = pll_prev & ~pll_locked & op_active;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q    <= '0;
            oc_q      <= 1'b0;
            wf_prev   <= 1'b0;
            pll_prev  <= 1'b1;
            prescale  <= '0;
            timestamp <= '0;
        end else begin
            mask_q   <= mask_next;
            oc_q     <= cmd_done;
            wf_prev  <= drv_write_fault;
            pll_prev <= pll_locked;
            if (prescale == PRE_LAST) begin
                prescale  <= '0;
                timestamp <= timestamp + TS_W'(1);
            end else begin
                prescale <= prescale + PRE_W'(1);
            end
        end
    end

    assign err_crc_data       = mask_q[ERRMASK_CRC_DATA];
    assign err_crc_addr       = mask_q[ERRMASK_CRC_ADDR];
    assign err_missing_am     = mask_q[ERRMASK_MISSING_AM];
    assign err_missing_dam    = mask_q[ERRMASK_MISSING_DAM];
    assign err_overrun        = mask_q[ERRMASK_OVERRUN];
    assign err_underrun       = mask_q[ERRMASK_UNDERRUN];
    assign err_seek           = mask_q[ERRMASK_SEEK];
    assign err_write_fault    = mask_q[ERRMASK_WRITE_FAULT];
    assign err_pll_unlock     = mask_q[ERRMASK_PLL_UNLOCK];
    assign operation_complete = oc_q;

    event_log_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_log (
        .clk       (clk),
        .reset     (reset),
        .clear     (log_clear),
        .push      (|mask_next),
        .push_data ({timestamp, cur_track, mask_next}),
        .pop       (log_pop),
        .valid     (log_valid),
        .head      (log_data),
        .overflow  (log_overflow),
        .count     (log_count)
    );

endmodule

// File: tb/tb_error_event_capture.sv
// Self-checking bench for error_event_capture. A behavioural model (error
// rules, a time base derived from elapsed cycles, and a queue for the log)
// predicts every output once per clock.
module tb_error_event_capture;
    localparam int unsigned DEPTH      = 16;
    localparam int unsigned TS_W       = 10;
    localparam int unsigned CLK_PER_US = 5;
    localparam int unsigned EW         = TS_W + 17;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_done = 1'b0, cmd_is_write = 1'b0;
    logic [7:0]    st1 = '0, st2 = '0;
    logic          seek_done = 1'b0, seek_fail = 1'b0;
    logic          drv_write_fault = 1'b0, pll_locked = 1'b1, op_active = 1'b0;
    logic [7:0]    cur_track = '0;
    logic          err_crc_data, err_crc_addr, err_missing_am, err_missing_dam;
    logic          err_overrun, err_underrun, err_seek, err_write_fault, err_pll_unlock;
    logic          operation_complete, log_valid, log_overflow;
    logic [EW-1:0] log_data;
    logic          log_pop = 1'b0, log_clear = 1'b0;
    logic [4:0]    log_count;

    error_event_capture #(
        .DEPTH      (DEPTH),
        .TS_W       (TS_W),
        .CLK_PER_US (CLK_PER_US)
    ) dut (
        .clk (clk), .reset (reset),
        .cmd_done (cmd_done), .cmd_is_write (cmd_is_write), .st1 (st1), .st2 (st2),
        .seek_done (seek_done), .seek_fail (seek_fail),
        .drv_write_fault (drv_write_fault), .pll_locked (pll_locked),
        .op_active (op_active), .cur_track (cur_track),
        .err_crc_data (err_crc_data), .err_crc_addr (err_crc_addr),
        .err_missing_am (err_missing_am), .err_missing_dam (err_missing_dam),
        .err_overrun (err_overrun), .err_underrun (err_underrun),
        .err_seek (err_seek), .err_write_fault (err_write_fault),
        .err_pll_unlock (err_pll_unlock), .operation_complete (operation_complete),
        .log_valid (log_valid), .log_data (log_data), .log_pop (log_pop),
        .log_clear (log_clear), .log_overflow (log_overflow), .log_count (log_count)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [EW-1:0] q[$];
    logic          m_ovf = 1'b0;
    int unsigned   cyc = 0;            // clock edges since reset released
    logic          m_prev_wf = 1'b0, m_prev_pll = 1'b1;
    logic [8:0]    exp_mask = '0;
    logic          exp_oc = 1'b0;
    logic [TS_W-1:0] last_ts;          // timestamp of the latest cause cycle

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: predict from current inputs, clock, compare, drop pulses.
    task automatic step();
        logic [8:0]      m;
        logic [TS_W-1:0] ts;
        logic [EW-1:0]   entry;
        m  = '0;
        ts = TS_W'((cyc / CLK_PER_US) % (1 << TS_W));
        if (cmd_done) begin
            m[0] = st1[5] &  st2[5];
            m[1] = st1[5] & ~st2[5];
            m[2] = st1[0] & ~st2[0];
            m[3] = st2[0];
            m[4] = st1[4] & ~cmd_is_write;
            m[5] = st1[4] &  cmd_is_write;
        end
        m[6] = seek_done & seek_fail;
        m[7] = drv_write_fault & ~m_prev_wf;
        m[8] = m_prev_pll & ~pll_locked & op_active;
        entry = {ts, cur_track, m};
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_ovf = 1'b0; cyc = 0; m_prev_wf = 1'b0; m_prev_pll = 1'b1;
            exp_mask = '0; exp_oc = 1'b0;
        end else begin
            last_ts = ts;
            if (log_clear) begin
                q.delete();
                m_ovf = 1'b0;
            end else begin
                if (log_pop && q.size() > 0) void'(q.pop_front());
                if (m != '0) begin
                    if (q.size() == DEPTH) begin
                        void'(q.pop_front());
                        m_ovf = 1'b1;
                    end
                    q.push_back(entry);
                end
            end
            cyc++;
            m_prev_wf = drv_write_fault;
            m_prev_pll = pll_locked;
            exp_mask = m;
            exp_oc = cmd_done;
        end
        #1;
        check("strobes", {err_pll_unlock, err_write_fault, err_seek, err_underrun,
                          err_overrun, err_missing_dam, err_missing_am, err_crc_addr,
                          err_crc_data}, exp_mask);
        check("op_complete", operation_complete, exp_oc);
        check("log_count", log_count, q.size());
        check("log_valid", log_valid, q.size() > 0);
        check("log_overflow", log_overflow, m_ovf);
        if (q.size() > 0) check("log_data", log_data, q[0]);
        cmd_done = 1'b0; seek_done = 1'b0; log_pop = 1'b0; log_clear = 1'b0;
    endtask

    task automatic seek_err();
        seek_done = 1'b1; seek_fail = 1'b1;
        step();
        seek_fail = 1'b0;
    endtask

    initial begin
        logic [TS_W-1:0] ev2_ts;
        logic [EW-1:0]   second;

        // Reset state
        reset = 1'b1; step(); step();
        reset = 1'b0;
        step();

        // CRC in data field on a read
        cur_track = 8'h2A;
        cmd_done = 1'b1; st1 = 8'h20; st2 = 8'h20; cmd_is_write = 1'b0;
        step();
        check("crc_data", err_crc_data, 1'b1);
        check("oc_crc", operation_complete, 1'b1);
        check("mask_crc", log_data[8:0], 9'h001);
        check("track_crc", log_data[16:9], 8'h2A);
        log_pop = 1'b1; step();

        // DE without DD, MA+MD, OR on a write
        cur_track = 8'h11;
        cmd_done = 1'b1; st1 = 8'h31; st2 = 8'h01; cmd_is_write = 1'b1;
        step();
        check("missing_am_suppressed", err_missing_am, 1'b0);
        check("mask_multi", log_data[8:0], 9'h02A);
        check("count_multi", log_count, 5'd1);
        log_pop = 1'b1; step();

        // PLL unlock gated by op_active
        op_active = 1'b0; pll_locked = 1'b0; step();
        check("pll_idle", err_pll_unlock, 1'b0);
        pll_locked = 1'b1; step();
        op_active = 1'b1; pll_locked = 1'b0; step();
        check("pll_active", err_pll_unlock, 1'b1);
        step();
        check("pll_one_cycle", err_pll_unlock, 1'b0);
        pll_locked = 1'b1; op_active = 1'b0; step();

        // Write fault rising edge
        drv_write_fault = 1'b1; step();
        check("wf_edge", err_write_fault, 1'b1);
        step();
        check("wf_level", err_write_fault, 1'b0);
        drv_write_fault = 1'b0; step();

        // 17 seek failures: oldest discarded, overflow set
        log_clear = 1'b1; step();
        for (int i = 0; i < 17; i++) begin
            cur_track = 8'(i);
            seek_err();
            if (i == 1) ev2_ts = last_ts;
            repeat (3) step();
        end
        check("ovf_count", log_count, 5'd16);
        check("ovf_flag", log_overflow, 1'b1);
        check("ovf_head_ts", log_data[EW-1:17], ev2_ts);

        // Full log with simultaneous push and pop
        log_clear = 1'b1; step();
        for (int i = 0; i < 16; i++) begin
            seek_err();
            step();
        end
        check("full_no_ovf", log_overflow, 1'b0);
        second = q[1];
        seek_done = 1'b1; seek_fail = 1'b1; log_pop = 1'b1;
        step();
        seek_fail = 1'b0;
        check("pushpop_count", log_count, 5'd16);
        check("pushpop_ovf", log_overflow, 1'b0);
        check("pushpop_head", log_data, second);

        // Timestamp wrap after CLK_PER_US * 2^TS_W cycles
        reset = 1'b1; step();
        reset = 1'b0;
        repeat (CLK_PER_US * (1 << TS_W)) step();
        seek_err();
        check("ts_wrap", log_data[EW-1:17], '0);
        log_clear = 1'b1; seek_done = 1'b1; seek_fail = 1'b1;
        step();
        seek_fail = 1'b0;
        check("clear_count", log_count, 5'd0);
        check("clear_valid", log_valid, 1'b0);
        check("clear_strobe", err_seek, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset           = ($urandom_range(399) == 0);
            cmd_done        = ($urandom_range(3) == 0);
            cmd_is_write    = 1'($urandom);
            st1             = 8'($urandom);
            st2             = 8'($urandom);
            seek_done       = ($urandom_range(5) == 0);
            seek_fail       = 1'($urandom);
            if ($urandom_range(5) == 0) drv_write_fault = ~drv_write_fault;
            if ($urandom_range(5) == 0) pll_locked = ~pll_locked;
            op_active       = 1'($urandom);
            cur_track       = 8'($urandom);
            log_pop         = ($urandom_range(2) == 0);
            log_clear       = ($urandom_range(63) == 0);
            step();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
